mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sits directly upstream of the variable-latency ram and drives its ramif request side.
- Arbitrates between the instruction-fetch port (read-only) and the data port (read/write).
- Registers the granted request and holds it stable until ram reports ACCESS, then returns the data with a one-cycle hit pulse.
- Provides data priority with bounded instruction starvation, a request timeout and a sticky error flag.

Parameters:
- MAX_DSTREAK, 4: consecutive data grants allowed while iREN is pending before the instruction port is forced.
- TIMEOUT, 64: cycles a grant may wait for ACCESS before entering error.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, synchronous, active-high
- iREN  in  1  instruction read request; held until ihit
- iaddr  in  32  instruction word address
- iload  out  32  instruction read data; valid while ihit=1
- ihit  out  1  one-cycle instruction completion pulse
- dREN  in  1  data read request; held until dhit
- dWEN  in  1  data write request; held until dhit
- daddr  in  32  data address
- dstore  in  32  write data
- dload  out  32  data read data; valid while dhit=1
- dhit  out  1  one-cycle data completion pulse
- ramREN  out  1  to ram
- ramWEN  out  1  to ram
- ramaddr  out  32  to ram
- ramstore  out  32  to ram
- ramload  in  32  from ram
- ramstate  in  2  ramstate_t from ram: FREE, BUSY, ACCESS, ERROR
- err  out  1  sticky: timeout or ramstate ERROR seen while granted

Behaviour:
- Reset (synchronous, active-high): state IDLE; all outputs are 0, including ramaddr, ramstore, iload and dload; streak and timeout counters are 0. RST asserted mid-transaction drops ramREN/ramWEN at the same edge and abandons the transaction with no hit.
- All outputs are registered. ramREN, ramWEN, ramaddr and ramstore change only on entry to a GRANT state and stay constant while in it.
- IDLE:
  - No request: stay in IDLE.
  - dREN|dWEN and (iREN=0 or streak<MAX_DSTREAK): go to GRANT_D. Latch daddr and dstore. If dWEN=1, ramWEN=1 and ramREN=0 (write wins when both are set); otherwise ramREN=1. Increment streak, saturating.
  - Otherwise, if iREN: go to GRANT_I with ramREN=1 and ramaddr=iaddr. Clear streak.
  - Streak is also cleared whenever iREN=0 in IDLE.
- GRANT_I / GRANT_D:
  - The timeout counter increments each cycle.
  - ramstate==ACCESS: go to RESP. Deassert ram strobes. Capture ramload into iload (GRANT_I) or into dload (GRANT_D read only; dload is unchanged on a write). Set ihit or dhit for the RESP cycle. Clear the timeout counter.
  - ramstate==ERROR, or the counter reaches TIMEOUT-1 without ACCESS: go to ERR. Strobes drop to 0; err=1.
  - Requester inputs are ignored while granted.
- RESP: lasts exactly one cycle with hit=1, then returns to IDLE. Requests are not sampled in RESP, so a requester still asserting in its hit cycle is never granted twice.
- ERR: absorbing until RST. Strobes are 0, hits are 0, err=1.
- The other port's request is never lost: it stays pending and is arbitrated on the next IDLE cycle.
- Latency with the ram at LAT=4: a request sampled in IDLE at cycle 0 produces hit in cycle 7. The minimum back-to-back issue interval per port is 8 cycles.

Test Plan:
- iREN=1, iaddr=0x0000_0040, ram LAT=4 preloaded with 0x1234_5678 -> ramREN rises in cycle 1; ihit=1 only in cycle 7 with iload=0x1234_5678; no second grant occurs.
- dWEN=1, daddr=0x0000_0100, dstore=0xDEAD_BEEF, then a dREN to the same address -> first dhit with dload unchanged; second dhit with dload=0xDEAD_BEEF.
- iREN and dREN held continuously, MAX_DSTREAK=4 -> grant order is D,D,D,D,I,D,D,D,D,I; every ihit and dhit is exactly one cycle wide.
- Ram stub that never reaches ACCESS, TIMEOUT=64 -> err=1 exactly 64 cycles after grant entry; ramREN=0 thereafter; no hits until RST; after RST, err=0 and the state is IDLE.
- RST pulsed for one cycle in the middle of a GRANT_D write -> ramWEN=0 the following cycle, no dhit, all outputs 0; a new iREN completes normally afterwards.
- ramstate forced to ERROR for one cycle during GRANT_I -> err=1 at the next edge and ihit never asserts.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - instruction/data arbiter driving the request side of the variable-latency ram
// Data wins by default; the instruction port is forced after MAX_DSTREAK back-to-back data grants.
module mem_arbiter #(
   parameter int MAX_DSTREAK = 4,
   parameter int TIMEOUT     = 64
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic [31:0] iload,
   output logic        ihit,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic [31:0] dload,
   output logic        dhit,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate,
   output logic        err
);

   localparam logic [1:0] RAM_ACCESS = 2'd2;
   localparam logic [1:0] RAM_ERROR  = 2'd3;
   localparam int         SW         = $clog2(MAX_DSTREAK + 1);
   localparam int         TW         = $clog2(TIMEOUT) + 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_GRANT_I = 3'd1,
      S_GRANT_D = 3'd2,
      S_RESP    = 3'd3,
      S_ERR     = 3'd4
   } state_t;

   state_t        r_state,    w_state;
   logic [SW-1:0] r_streak,   w_streak;
   logic [TW-1:0] r_tmo,      w_tmo;
   logic          r_ramren,   w_ramren;
   logic          r_ramwen,   w_ramwen;
   logic [31:0]   r_ramaddr,  w_ramaddr;
   logic [31:0]   r_ramstore, w_ramstore;
   logic [31:0]   r_iload,    w_iload;
   logic [31:0]   r_dload,    w_dload;
   logic          r_ihit,     w_ihit;
   logic          r_dhit,     w_dhit;
   logic          r_err,      w_err;

   logic          w_dreq;
   logic          w_streak_ok;
   logic [SW-1:0] w_streak_inc;

   assign w_dreq       = dREN | dWEN;
   assign w_streak_ok  = (r_streak < SW'(MAX_DSTREAK));
   assign w_streak_inc = w_streak_ok ? (r_streak + SW'(1)) : r_streak;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state    <= S_IDLE;
         r_streak   <= '0;
         r_tmo      <= '0;
         r_ramren   <= 1'b0;
         r_ramwen   <= 1'b0;
         r_ramaddr  <= '0;
         r_ramstore <= '0;
         r_iload    <= '0;
         r_dload    <= '0;
         r_ihit     <= 1'b0;
         r_dhit     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_streak   <= w_streak;
         r_tmo      <= w_tmo;
         r_ramren   <= w_ramren;
         r_ramwen   <= w_ramwen;
         r_ramaddr  <= w_ramaddr;
         r_ramstore <= w_ramstore;
         r_iload    <= w_iload;
         r_dload    <= w_dload;
         r_ihit     <= w_ihit;
         r_dhit     <= w_dhit;
         r_err      <= w_err;
      end
   end

   always_comb begin
      w_state    = r_state;
      w_streak   = r_streak;
      w_tmo      = r_tmo;
      w_ramren   = r_ramren;
      w_ramwen   = r_ramwen;
      w_ramaddr  = r_ramaddr;
      w_ramstore = r_ramstore;
      w_iload    = r_iload;
      w_dload    = r_dload;
      w_ihit     = 1'b0;
      w_dhit     = 1'b0;
      w_err      = r_err;

      case (r_state)
         S_IDLE: begin
            w_tmo = '0;
            if (w_dreq && (!iREN || w_streak_ok)) begin
               // write wins when both data strobes are raised together
               w_state    = S_GRANT_D;
               w_ramaddr  = daddr;
               w_ramstore = dstore;
               w_ramwen   = dWEN;
               w_ramren   = ~dWEN;
               w_streak   = iREN ? w_streak_inc : '0;
            end else if (iREN) begin
               w_state   = S_GRANT_I;
               w_ramaddr = iaddr;
               w_ramren  = 1'b1;
               w_ramwen  = 1'b0;
               w_streak  = '0;
            end else begin
               w_streak = '0;
            end
         end

         S_GRANT_I, S_GRANT_D: begin
            if (ramstate == RAM_ACCESS) begin
               w_state  = S_RESP;
               w_ramren = 1'b0;
               w_ramwen = 1'b0;
               w_tmo    = '0;
               if (r_state == S_GRANT_I) begin
                  w_iload = ramload;
                  w_ihit  = 1'b1;
               end else begin
                  if (!r_ramwen) begin
                     w_dload = ramload;
                  end
                  w_dhit = 1'b1;
               end
            end else if ((ramstate == RAM_ERROR) || (r_tmo == TMO_LAST)) begin
               w_state  = S_ERR;
               w_ramren = 1'b0;
               w_ramwen = 1'b0;
               w_err    = 1'b1;
            end else begin
               w_tmo = r_tmo + TW'(1);
            end
         end

         // one hit cycle; requests are deliberately not sampled here
         S_RESP: begin
            w_state = S_IDLE;
         end

         S_ERR: begin
            w_ramren = 1'b0;
            w_ramwen = 1'b0;
            w_err    = 1'b1;
         end

         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

   assign ramREN   = r_ramren;
   assign ramWEN   = r_ramwen;
   assign ramaddr  = r_ramaddr;
   assign ramstore = r_ramstore;
   assign iload    = r_iload;
   assign dload    = r_dload;
   assign ihit     = r_ihit;
   assign dhit     = r_dhit;
   assign err      = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a ram stub and transaction-level model
module tb_mem_arbiter;

   localparam int MAX_DSTREAK = 4;
   localparam int TIMEOUT     = 64;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        iREN = 1'b0;
   logic [31:0] iaddr = '0;
   logic [31:0] iload;
   logic        ihit;
   logic        dREN = 1'b0;
   logic        dWEN = 1'b0;
   logic [31:0] daddr = '0;
   logic [31:0] dstore = '0;
   logic [31:0] dload;
   logic        dhit;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload = '0;
   logic [1:0]  ramstate = 2'd0;
   logic        err;

   mem_arbiter #(.MAX_DSTREAK(MAX_DSTREAK), .TIMEOUT(TIMEOUT)) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dhit(dhit),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .err(err)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ram stub: FREE when idle, BUSY while strobed, ACCESS on the (lat+2)-th strobed cycle
   logic [31:0] mem [logic [31:0]];
   int  lat = 4;
   int  cnt = 0;
   int  err_at = -1;
   bit  never_access = 0;
   bit  rnd_lat = 0;

   always @(negedge CLK) begin
      if (ramREN === 1'b1 || ramWEN === 1'b1) begin
         cnt++;
         if (err_at >= 0 && cnt == err_at) begin
            ramstate = 2'd3;
         end else if (!never_access && cnt == lat + 2) begin
            ramstate = 2'd2;
            if (ramWEN === 1'b1) begin
               mem[ramaddr] = ramstore;
               ramload = $urandom;
            end else begin
               ramload = mem.exists(ramaddr) ? mem[ramaddr] : 32'h0;
            end
         end else begin
            ramstate = 2'd1;
         end
      end else begin
         cnt = 0;
         ramstate = 2'd0;
         if (rnd_lat) lat = $urandom_range(0, 6);
      end
   end

   // behavioural model: who owns the ram, how long it has waited, and whether a reply/fault is pending
   int          m_owner = 0;
   bit          m_resp = 0;
   bit          m_dead = 0;
   int          m_wait = 0;
   int          m_streak = 0;
   bit          m_ireq, m_dreq;
   logic        e_ihit = 0, e_dhit = 0, e_ren = 0, e_wen = 0, e_err = 0;
   logic [31:0] e_iload = 0, e_dload = 0, e_addr = 0, e_store = 0;

   always @(posedge CLK) begin
      e_ihit = 0;
      e_dhit = 0;
      m_ireq = iREN;
      m_dreq = dREN | dWEN;
      if (RST) begin
         m_owner = 0; m_resp = 0; m_dead = 0; m_wait = 0; m_streak = 0;
         e_iload = 0; e_dload = 0; e_addr = 0; e_store = 0;
         e_ren = 0; e_wen = 0; e_err = 0;
      end else if (m_dead) begin
         e_ren = 0; e_wen = 0; e_err = 1;
      end else if (m_resp) begin
         m_resp = 0;
      end else if (m_owner == 0) begin
         if (m_dreq && (!m_ireq || m_streak < MAX_DSTREAK)) begin
            m_owner = 2; m_wait = 0;
            e_addr = daddr; e_store = dstore; e_wen = dWEN; e_ren = !dWEN;
            m_streak = m_ireq ? ((m_streak < MAX_DSTREAK) ? m_streak + 1 : MAX_DSTREAK) : 0;
         end else if (m_ireq) begin
            m_owner = 1; m_wait = 0;
            e_addr = iaddr; e_ren = 1; e_wen = 0;
            m_streak = 0;
         end else begin
            m_streak = 0;
         end
      end else begin
         m_wait++;
         if (ramstate == 2'd2) begin
            if (m_owner == 1) begin
               e_iload = ramload; e_ihit = 1;
            end else begin
               if (!e_wen) e_dload = ramload;
               e_dhit = 1;
            end
            m_owner = 0; m_resp = 1; e_ren = 0; e_wen = 0;
         end else if (ramstate == 2'd3 || m_wait == TIMEOUT) begin
            m_dead = 1; m_owner = 0; e_err = 1; e_ren = 0; e_wen = 0;
         end
      end
   end

   always @(negedge CLK) begin
      if (chk_en) begin
         chk("ihit", ihit, e_ihit);
         chk("dhit", dhit, e_dhit);
         chk("iload", iload, e_iload);
         chk("dload", dload, e_dload);
         chk("ramREN", ramREN, e_ren);
         chk("ramWEN", ramWEN, e_wen);
         chk("ramaddr", ramaddr, e_addr);
         if (e_wen) chk("ramstore", ramstore, e_store);
         chk("err", err, e_err);
      end
   end

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ihit0"}, ihit, 32'd0);
      chk({tag, "_dhit0"}, dhit, 32'd0);
      chk({tag, "_iload0"}, iload, 32'd0);
      chk({tag, "_dload0"}, dload, 32'd0);
      chk({tag, "_ramREN0"}, ramREN, 32'd0);
      chk({tag, "_ramWEN0"}, ramWEN, 32'd0);
      chk({tag, "_ramaddr0"}, ramaddr, 32'd0);
      chk({tag, "_ramstore0"}, ramstore, 32'd0);
      chk({tag, "_err0"}, err, 32'd0);
   endtask

   task automatic run_until_hit(input bit port_d, input int budget, output int cyc);
      cyc = -1;
      for (int k = 1; k <= budget; k++) begin
         @(negedge CLK);
         if ((port_d ? dhit : ihit) === 1'b1) begin
            cyc = k;
            break;
         end
      end
   endtask

   int    cyc, cnt_a, nhits, op;
   string got, want;
   logic  prev_i, prev_d;
   byte   b;

   initial begin
      mem[32'h40] = 32'h1234_5678;
      mem[32'h80] = 32'hA5A5_0080;
      for (int a = 0; a < 16; a++) mem[32'(a * 4)] = $urandom;

      do_reset();
      chk_en = 1;
      check_zero("reset");

      // single instruction fetch, LAT=4
      iaddr = 32'h40; iREN = 1;
      @(negedge CLK);
      chk("t1_ramREN_cycle1", ramREN, 32'd1);
      chk("t1_ramaddr", ramaddr, 32'h40);
      run_until_hit(0, 20, cyc);
      chk("t1_ihit_cycle", cyc + 1, 32'd7);
      chk("t1_iload", iload, 32'h1234_5678);
      iREN = 0;
      cnt_a = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge CLK);
         if (ramREN === 1'b1 || ihit === 1'b1) cnt_a++;
      end
      chk("t1_no_second_grant", cnt_a, 32'd0);

      // write then read back the same address
      do_reset();
      daddr = 32'h100; dstore = 32'hDEAD_BEEF; dWEN = 1;
      run_until_hit(1, 20, cyc);
      chk("t3_wr_hit_cycle", cyc, 32'd7);
      chk("t3_wr_dload_unchanged", dload, 32'd0);
      dWEN = 0; dREN = 1; dstore = 32'h0;
      run_until_hit(1, 20, cyc);
      chk("t3_rd_interval", cyc, 32'd8);
      chk("t3_rd_dload", dload, 32'hDEAD_BEEF);
      dREN = 0;

      // both ports held: bounded instruction starvation
      do_reset();
      iaddr = 32'h40; iREN = 1; daddr = 32'h100; dREN = 1;
      got = ""; want = "DDDDIDDDDI"; prev_i = 0; prev_d = 0;
      for (int k = 0; k < 200 && got.len() < 10; k++) begin
         @(negedge CLK);
         if (ihit === 1'b1) begin
            chk("t4_ihit_width", prev_i, 32'd0);
            got = {got, "I"};
         end
         if (dhit === 1'b1) begin
            chk("t4_dhit_width", prev_d, 32'd0);
            got = {got, "D"};
         end
         prev_i = ihit; prev_d = dhit;
      end
      iREN = 0; dREN = 0;
      chk("t4_hit_count", got.len(), 32'd10);
      for (int i = 0; i < 10; i++) begin
         b = (i < got.len()) ? got[i] : 8'h3f;
         chk("t4_grant_order", b, want[i]);
      end

      // ram never answers: timeout into sticky error
      do_reset();
      never_access = 1; iaddr = 32'h80; iREN = 1;
      cnt_a = 0;
      for (int k = 1; k <= 80; k++) begin
         @(negedge CLK);
         if (k == 64) chk("t5_err_before_timeout", err, 32'd0);
         if (k == 65) chk("t5_err_at_timeout", err, 32'd1);
         if (k == 65 || k == 80) chk("t5_ramREN_dropped", ramREN, 32'd0);
         if (ihit === 1'b1 || dhit === 1'b1) cnt_a++;
      end
      chk("t5_no_hits", cnt_a, 32'd0);
      chk("t5_err_sticky", err, 32'd1);
      never_access = 0;
      @(negedge CLK);
      RST = 1;
      @(negedge CLK);
      check_zero("t5_after_rst");
      RST = 0;
      run_until_hit(0, 20, cyc);
      chk("t5_recover_hit_cycle", cyc, 32'd7);
      chk("t5_recover_iload", iload, 32'hA5A5_0080);
      iREN = 0;

      // reset in the middle of a data write
      do_reset();
      daddr = 32'h500; dstore = 32'hCAFE_F00D; dWEN = 1;
      @(negedge CLK);
      chk("t6_ramWEN_cycle1", ramWEN, 32'd1);
      chk("t6_ramstore", ramstore, 32'hCAFE_F00D);
      @(negedge CLK);
      RST = 1; dWEN = 0;
      @(negedge CLK);
      check_zero("t6_mid_rst");
      RST = 0;
      cnt_a = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge CLK);
         if (dhit === 1'b1) cnt_a++;
      end
      chk("t6_no_dhit", cnt_a, 32'd0);
      chk("t6_write_abandoned", mem.exists(32'h500), 32'd0);
      iaddr = 32'h40; iREN = 1;
      run_until_hit(0, 20, cyc);
      chk("t6_ifetch_hit_cycle", cyc, 32'd7);
      chk("t6_ifetch_iload", iload, 32'h1234_5678);
      iREN = 0;

      // one-cycle ram ERROR during an instruction grant
      do_reset();
      err_at = 2; iaddr = 32'h40; iREN = 1;
      @(negedge CLK);
      @(negedge CLK);
      chk("t7_err_before", err, 32'd0);
      @(negedge CLK);
      chk("t7_err_after", err, 32'd1);
      chk("t7_ramREN_dropped", ramREN, 32'd0);
      cnt_a = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge CLK);
         if (ihit === 1'b1) cnt_a++;
      end
      chk("t7_no_ihit", cnt_a, 32'd0);
      err_at = -1; iREN = 0;
      do_reset();
      check_zero("t7_after_rst");

      // randomized traffic with random ram latency
      rnd_lat = 1;
      nhits = 0;
      for (int c = 0; c < 1500; c++) begin
         @(negedge CLK);
         if (ihit === 1'b1 || dhit === 1'b1) nhits++;
         if (ihit === 1'b1) iREN = 0;
         if (dhit === 1'b1) begin
            dREN = 0; dWEN = 0;
         end
         if (!iREN && $urandom_range(0, 2) == 0) begin
            iaddr = 32'($urandom_range(0, 15)) << 2;
            iREN = 1;
         end
         if (!dREN && !dWEN && $urandom_range(0, 2) == 0) begin
            daddr = 32'($urandom_range(0, 15)) << 2;
            dstore = $urandom;
            op = $urandom_range(0, 3);
            dREN = (op != 1);
            dWEN = (op >= 1);
         end
      end
      iREN = 0; dREN = 0; dWEN = 0;
      for (int k = 0; k < 20; k++) @(negedge CLK);
      chk("rand_enough_hits", (nhits > 40) ? 32'd1 : 32'd0, 32'd1);
      chk("rand_err_clear", err, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
